crc16_arbiter: RTL and testbench
================================

Name: crc16_arbiter

Overview:
Shares one CRC16 engine among NUM_REQ frame parsers. Each parser posts a job: up to eight 16-bit payload words packed in 128 bits, plus a word count. The arbiter grants jobs round-robin, clears the engine, streams the words, waits for the result and returns it to the owning requester. It sits between the parser array and the single CRC16 engine, on the parser-side clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT, 63, maximum cycles spent in WAIT for crc16_done before the job is aborted.

Ports:
clk_in  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester job pending; held high until that requester's req_ready pulses.
req_data  in  NUM_REQ*128  per-requester payload; slice i is [i*128 +: 128]; word k is [k*16 +: 16].
req_count  in  NUM_REQ*4  per-requester word count; slice i is [i*4 +: 4].
req_ready  out  NUM_REQ  one-hot, one-cycle grant/accept pulse.
rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the job owner.
rsp_crc  out  16  CRC result; valid only with rsp_valid.
rsp_err  out  1  job aborted (bad count or timeout); valid only with rsp_valid.
crc16_clear  out  1  one-cycle engine seed reset.
crc16_valid  out  1  word strobe to engine.
data_to_crc  out  16  word to engine.
crc16_done  in  1  engine result ready.
data_from_crc  in  16  engine result.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0.
  - State IDLE; RR pointer 0; job and counters cleared.
  - Reset mid-job drops the job and issues no response.
- State machine: IDLE, CLEAR, SEND, WAIT, RESP. All outputs are registered.
- IDLE:
  - Scan req_valid starting at the RR pointer, wrapping modulo NUM_REQ.
  - First hit i: req_ready[i]=1 for one cycle. Latch slice i of req_data and req_count, and owner id i.
  - Set RR pointer to (i+1) mod NUM_REQ.
  - If the latched count is 0 or greater than 8: go to RESP with error. Otherwise go to CLEAR.
  - No requests: stay in IDLE; pointer unchanged.
- CLEAR: crc16_clear=1 for one cycle, then go to SEND.
- SEND:
  - crc16_valid=1 on consecutive cycles, one word per cycle, words k=0..count-1 in ascending order (low word first).
  - After the last word, go to WAIT. The engine sees exactly count strobes and no gaps.
- WAIT:
  - Timeout counter starts at 0 and increments each cycle.
  - crc16_done=1: capture data_from_crc, go to RESP.
  - Counter reaches TIMEOUT with no done: go to RESP with error.
  - crc16_done is ignored in every state other than WAIT.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - Normal result: rsp_crc = captured value, rsp_err=0.
  - Error result: rsp_crc=0, rsp_err=1.
  - Then go to IDLE.
- Timing, with the grant in cycle T and count N valid:
  - crc16_clear at T+1.
  - Words at T+2..T+1+N.
  - WAIT from T+2+N.
  - rsp_valid the cycle after done is sampled.
- Timing, bad count: rsp_valid at T+1; no crc16_clear and no crc16_valid.
- Next grant is no earlier than the cycle after RESP. One job is in flight at a time.
- req_valid deasserted before a grant is legal; that requester is skipped.
- A requester's req_valid seen while the arbiter is busy is evaluated at the next IDLE.
- Inputs are not sampled after the grant; requesters may change req_data after req_ready.
- Fairness: with all requesters continuously valid, each is served once per NUM_REQ jobs.

Test Plan:
1. Single job, req 0, count 2, words 0x1234, 0xABCD; engine model returns done=1 and data_from_crc=0xBEEF two cycles after the last word.
   -> req_ready[0] at T, crc16_clear at T+1, data_to_crc 0x1234 then 0xABCD at T+2 and T+3, rsp_valid[0] with rsp_crc=0xBEEF and rsp_err=0.
2. All four requesters valid at once, count 1 each, with a prompt engine.
   -> grant order 0,1,2,3,0. Each rsp_valid goes to the correct owner.
   -> A new req_valid[1] raised during job 0 is served after 2 and 3, not before.
3. req 2 with count 0, then req 3 with count 9.
   -> each gets a req_ready, then rsp_valid one cycle later with rsp_err=1 and rsp_crc=0.
   -> crc16_clear and crc16_valid never assert.
4. Engine never raises done, TIMEOUT=63, count 8.
   -> exactly 8 word strobes, then rsp_valid with rsp_err=1 exactly 64 cycles after WAIT entry (counter reaches 63).
   -> the next grant then proceeds normally.
5. crc16_done pulsed during SEND of a count-4 job.
   -> ignored; all 4 words are sent; the result is taken from the done pulse in WAIT.
6. rst_n asserted during SEND.
   -> all outputs 0 immediately, no rsp_valid, RR pointer 0.
   -> after release, the pending req_valid[0] is granted first.

Source files
------------

// File: rtl/crc16_arbiter.sv
// rtl/crc16_arbiter.sv - round-robin arbiter sharing one CRC16 engine among frame parsers
// Grants one job at a time, streams its words to the engine and returns the result.
module crc16_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]   req_count,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_crc,
  output logic                   rsp_err,
  output logic                   crc16_clear,
  output logic                   crc16_valid,
  output logic [15:0]            data_to_crc,
  input  logic                   crc16_done,
  input  logic [15:0]            data_from_crc
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEND, S_WAIT, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [127:0]         data_q, data_d;
  logic [3:0]           count_q, count_d;
  logic [3:0]           idx_q, idx_d;
  logic [CW-1:0]        tmo_q, tmo_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_crc_q, rsp_crc_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 clear_q, clear_d;
  logic                 valid_q, valid_d;
  logic [15:0]          word_q, word_d;

  logic                 hit;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       cand;
  logic [3:0]           pick_count;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    count_d     = count_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_crc_d   = '0;
    rsp_err_d   = 1'b0;
    clear_d     = 1'b0;
    valid_d     = 1'b0;
    word_d      = '0;
    hit         = 1'b0;
    pick        = '0;
    cand        = '0;
    pick_count  = '0;

    // First pending requester at or after the round-robin pointer
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NUM_REQ);
      if (!hit && req_valid[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
    pick_count = req_count[pick*4 +: 4];

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          req_ready_d[pick] = 1'b1;
          owner_d           = pick;
          data_d            = req_data[pick*128 +: 128];
          count_d           = pick_count;
          rr_d              = IDW'((int'(pick) + 1) % NUM_REQ);
          state_d           = ((pick_count == 4'd0) || (pick_count > 4'd8)) ? S_RESP : S_CLEAR;
        end
      end
      S_CLEAR: begin
        clear_d = 1'b1;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // One extra SEND cycle after the last word keeps done ignored while it is on the bus
        if (idx_q < count_q) begin
          valid_d = 1'b1;
          word_d  = data_q[{idx_q[2:0], 4'b0000} +: 16];
          idx_d   = idx_q + 4'd1;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (crc16_done) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_crc_d            = data_from_crc;
          state_d              = S_IDLE;
        end else if (tmo_q == CW'(TIMEOUT)) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
          state_d              = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d            = 1'b1;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      data_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_crc_q   <= '0;
      rsp_err_q   <= 1'b0;
      clear_q     <= 1'b0;
      valid_q     <= 1'b0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_crc_q   <= rsp_crc_d;
      rsp_err_q   <= rsp_err_d;
      clear_q     <= clear_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_crc     = rsp_crc_q;
  assign rsp_err     = rsp_err_q;
  assign crc16_clear = clear_q;
  assign crc16_valid = valid_q;
  assign data_to_crc = word_q;

endmodule

// File: tb/tb_crc16_arbiter.sv
// tb/tb_crc16_arbiter.sv - randomized bench for crc16_arbiter against a job-level reference model
module tb_crc16_arbiter;
  localparam int NR  = 4;
  localparam int TMO = 63;

  logic            clk_in = 1'b0;
  logic            rst_n  = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*128-1:0] req_data = '0;
  logic [NR*4-1:0] req_count = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [15:0]     rsp_crc;
  logic            rsp_err;
  logic            crc16_clear;
  logic            crc16_valid;
  logic [15:0]     data_to_crc;
  logic            crc16_done = 1'b0;
  logic [15:0]     data_from_crc = '0;

  crc16_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_count(req_count),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
    .crc16_clear(crc16_clear), .crc16_valid(crc16_valid), .data_to_crc(data_to_crc),
    .crc16_done(crc16_done), .data_from_crc(data_from_crc)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr = 0;
  int idle_from = 0;
  int jobs_done = 0;
  bit gen_en = 1'b0;
  logic [NR-1:0] exp_ready = '0;

  // Job in flight: grant cycle, owner, word count, planned engine done cycle, response cycle
  bit          j_act = 1'b0;
  bit          j_bad, j_err;
  int          j_t, j_own, j_n, j_done, j_rsp;
  logic [15:0] j_words[8];
  logic [15:0] j_crc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_crc", rsp_crc, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_crc16_clear", crc16_clear, 0);
    check_eq("rst_crc16_valid", crc16_valid, 0);
    check_eq("rst_data_to_crc", data_to_crc, 0);
  endtask

  task automatic new_request(input int i);
    req_valid[i] = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      int r;
      r = $urandom_range(0, 7);
      req_count[i*4 +: 4] = (r == 0) ? 4'd0 : 4'(8 + r);
    end else begin
      req_count[i*4 +: 4] = 4'($urandom_range(1, 8));
    end
    req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_job(input int o);
    int r;
    j_act = 1'b1;
    j_t   = cyc;
    j_own = o;
    j_n   = int'(req_count[o*4 +: 4]);
    j_bad = (j_n == 0) || (j_n > 8);
    for (int k = 0; k < 8; k++) j_words[k] = req_data[o*128 + k*16 +: 16];
    j_crc = 16'($urandom);
    if (j_bad) begin
      j_done = -1;
      j_err  = 1'b1;
      j_rsp  = cyc + 1;
    end else begin
      r = $urandom_range(0, 19);
      if (r < 2)      j_done = -1;
      else if (r < 3) j_done = cyc + 2 + j_n + TMO;
      else            j_done = cyc + 2 + j_n + $urandom_range(0, 5);
      j_err = (j_done < 0);
      j_rsp = j_err ? (cyc + 2 + j_n + TMO + 1) : (j_done + 1);
    end
    idle_from = j_rsp;
    req_valid[o] = 1'b0;
    req_data[o*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_count[o*4 +: 4] = 4'($urandom);
  endtask

  task automatic check_outputs();
    logic [NR-1:0] e_rsp;
    bit            e_clr, e_val;
    logic [15:0]   e_word;
    check_eq("req_ready", req_ready, exp_ready);
    if (exp_ready != 0) begin
      for (int i = 0; i < NR; i++) if (exp_ready[i]) start_job(i);
    end
    e_rsp = '0; e_clr = 1'b0; e_val = 1'b0; e_word = '0;
    if (j_act) begin
      e_clr = !j_bad && (cyc == j_t + 1);
      e_val = !j_bad && (cyc >= j_t + 2) && (cyc <= j_t + 1 + j_n);
      if (e_val) e_word = j_words[cyc - j_t - 2];
      if (cyc == j_rsp) e_rsp = NR'(1) << j_own;
    end
    check_eq("crc16_clear", crc16_clear, e_clr);
    check_eq("crc16_valid", crc16_valid, e_val);
    if (e_val) check_eq("data_to_crc", data_to_crc, e_word);
    check_eq("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp != 0) begin
      check_eq("rsp_err", rsp_err, j_err);
      check_eq("rsp_crc", rsp_crc, j_err ? 16'h0 : j_crc);
      j_act = 1'b0;
      jobs_done++;
    end
  endtask

  task automatic drive_inputs();
    bit in_wait;
    in_wait = j_act && !j_bad && (cyc >= j_t + 2 + j_n);
    crc16_done    = 1'b0;
    data_from_crc = 16'($urandom);
    if (in_wait && cyc == j_done) begin
      crc16_done    = 1'b1;
      data_from_crc = j_crc;
    end else if (!in_wait && $urandom_range(0, 6) == 0) begin
      crc16_done = 1'b1;
    end
    if (gen_en) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) new_request(i);
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic predict();
    bit found;
    int i;
    exp_ready = '0;
    found = 1'b0;
    if (rst_n && cyc >= idle_from) begin
      for (int k = 0; k < NR; k++) begin
        i = (rr + k) % NR;
        if (!found && req_valid[i]) begin
          found = 1'b1;
          exp_ready[i] = 1'b1;
          rr = (i + 1) % NR;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    cyc++;
    check_outputs();
    drive_inputs();
    predict();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    j_act = 1'b0; rr = 0; exp_ready = '0; crc16_done = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      cyc++;
      check_reset_outputs();
    end
    rst_n = 1'b1;
    idle_from = cyc;
    predict();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_valid != 0 || j_act) && n < 3000) begin
      step();
      n++;
    end
    check_eq("drain_bound", (req_valid == 0 && !j_act), 1);
  endtask

  initial begin
    int n;
    #2;
    do_reset();

    gen_en = 1'b1;
    while (jobs_done < 80 && cyc < 30000) step();
    gen_en = 1'b0;
    drain();

    // All requesters valid at once with single-word jobs
    for (int i = 0; i < NR; i++) begin
      new_request(i);
      req_count[i*4 +: 4] = 4'd1;
    end
    predict();
    drain();

    // Reset while a job is streaming; requests pending at reset are re-arbitrated from 0
    new_request(1);
    req_count[1*4 +: 4] = 4'd4;
    predict();
    n = 0;
    while (!(j_act && j_own == 1 && cyc == j_t + 3) && n < 200) begin
      step();
      n++;
    end
    check_eq("rst_setup_bound", (j_act && j_own == 1), 1);
    new_request(0); req_count[0*4 +: 4] = 4'd2;
    new_request(3); req_count[3*4 +: 4] = 4'd2;
    do_reset();
    n = 0;
    while (req_ready == 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("rst_first_grant", req_ready, 4'b0001);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
